pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch/execute program-counter sequencer with branch, jump, jr,
//            illegal-op and interrupt vectoring plus cycle/retire counters.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [ADDR_W-1:0] XADR_VEC  = 32'h8000_0008,
    parameter int                CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              retire,
    input  logic [2:0]        pc_src,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              irq,
    output logic [ADDR_W-1:0] epc,
    output logic              epc_we,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [1:0] c_ST_RST   = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_EXEC  = 2'd2;

    localparam int c_LOW_W = ADDR_W - 1;
    localparam int c_JW    = (ADDR_W > 32) ? ADDR_W : 32;

    localparam logic [2:0] c_SRC_SEQ  = 3'b000;
    localparam logic [2:0] c_SRC_BR   = 3'b001;
    localparam logic [2:0] c_SRC_JMP  = 3'b010;
    localparam logic [2:0] c_SRC_JR   = 3'b011;
    localparam logic [2:0] c_SRC_XADR = 3'b101;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_fetch_done;
    logic              w_accept;

    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic [ADDR_W-1:0] r_epc;
    logic              r_epc_we;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic              w_k;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_br_target;
    logic [c_JW-1:0]   w_jump_full;
    logic [ADDR_W-1:0] w_jump_target;
    logic [ADDR_W-1:0] w_norm_pc;
    logic              w_vec;
    logic [ADDR_W-1:0] w_vec_pc;
    logic [ADDR_W-1:0] w_vec_epc;
    logic              w_irq_take;
    logic              w_take_vector;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_epc_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fetch_done = 1'b0;
        w_accept     = 1'b0;
        imem_req     = 1'b0;
        inst_valid   = 1'b0;
        case (r_state)
            c_ST_RST: begin
                w_state_nxt = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_fetch_done = 1'b1;
                    w_state_nxt  = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                inst_valid = 1'b1;
                if (retire) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = c_ST_RST;
            end
        endcase
    end

    // The kernel bit rides above all address arithmetic; carries never reach it.
    assign w_k           = r_pc[ADDR_W-1];
    assign w_pc_plus4    = {w_k, r_pc[ADDR_W-2:0] + c_LOW_W'(4)};
    assign w_br_target   = {w_k, w_pc_plus4[ADDR_W-2:0] + {br_offset[ADDR_W-4:0], 2'b00}};
    assign w_jump_full   = c_JW'({w_pc_plus4[ADDR_W-1 -: 4], r_inst[25:0], 2'b00});
    assign w_jump_target = w_jump_full[ADDR_W-1:0];

    always_comb begin
        w_norm_pc = w_pc_plus4;
        w_vec     = 1'b0;
        w_vec_pc  = ILLOP_VEC;
        w_vec_epc = w_pc_plus4;
        case (pc_src)
            c_SRC_SEQ: w_norm_pc = w_pc_plus4;
            c_SRC_BR:  w_norm_pc = br_taken ? w_br_target : w_pc_plus4;
            c_SRC_JMP: w_norm_pc = w_jump_target;
            c_SRC_JR: begin
                w_norm_pc = jr_target;
                if (jr_target[1:0] != 2'b00) begin
                    w_vec     = 1'b1;
                    w_vec_epc = r_pc;
                end
            end
            c_SRC_XADR: begin
                w_vec    = 1'b1;
                w_vec_pc = XADR_VEC;
            end
            default: w_vec = 1'b1;
        endcase

        // Masked only when staying in kernel; a jr out of kernel lets a pending irq in.
        w_irq_take    = irq & ~w_vec & ~(w_k & w_norm_pc[ADDR_W-1]);
        w_take_vector = w_vec | w_irq_take;
        w_pc_nxt      = w_norm_pc;
        w_epc_nxt     = w_norm_pc;
        if (w_vec) begin
            w_pc_nxt  = w_vec_pc;
            w_epc_nxt = w_vec_epc;
        end else if (w_irq_take) begin
            w_pc_nxt  = XADR_VEC;
            w_epc_nxt = w_norm_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_inst       <= 32'd0;
            r_epc        <= '0;
            r_epc_we     <= 1'b0;
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            r_epc_we    <= 1'b0;
            if (w_fetch_done) begin
                r_inst <= imem_data;
            end
            if (w_accept) begin
                r_pc         <= w_pc_nxt;
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
                if (w_take_vector) begin
                    r_epc    <= w_epc_nxt;
                    r_epc_we <= 1'b1;
                end
            end
        end
    end

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign inst       = r_inst;
    assign epc        = r_epc;
    assign epc_we     = r_epc_we;
    assign cycle_cnt  = r_cycle_cnt;
    assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Scenario bench for pc_sequencer; expected fetch addresses are
//            queued as each retire is driven and checked at the next fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic [2:0]  pc_src;
    logic        br_taken;
    logic [31:0] br_offset;
    logic [31:0] jr_target;
    logic        irq;
    logic [31:0] epc;
    logic        epc_we;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] addr_q[$];
    logic [31:0] fetch_cyc;
    logic [31:0] prev_fetch_cyc;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .retire     (retire),
        .pc_src     (pc_src),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .jr_target  (jr_target),
        .irq        (irq),
        .epc        (epc),
        .epc_we     (epc_we),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_fetch();
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        if (!imem_req) begin
            n_tests++;
            n_fail++;
            $display("FAIL fetch_timeout: imem_req=%0b after %0d cycles, required 1", imem_req, n);
        end
    endtask

    // One full instruction: fetch check, ack, retire with the given controls.
    task automatic do_instr(input logic [2:0] src, input logic bt, input logic [31:0] off,
                            input logic [31:0] jrt, input logic irq_v, input logic [31:0] word,
                            input logic [31:0] exp_next, input logic exp_vec,
                            input logic [31:0] exp_epc);
        logic [31:0] exp_addr;
        wait_fetch();
        exp_addr = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hXXXX_XXXX;
        prev_fetch_cyc = fetch_cyc;
        fetch_cyc      = cycle_cnt;
        n_tests++;
        if (imem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL fetch_addr: got %h, required %h", imem_addr, exp_addr);
        end
        n_tests++;
        if (pc_plus4 !== exp_addr + 32'd4) begin
            n_fail++;
            $display("FAIL pc_plus4: got %h, required %h", pc_plus4, exp_addr + 32'd4);
        end
        imem_ack  = 1'b1;
        imem_data = word;
        step();
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        n_tests++;
        if (inst_valid !== 1'b1 || inst !== word || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL exec_inst: valid=%0b inst=%h req=%0b, required 1/%h/0",
                     inst_valid, inst, imem_req, word);
        end
        retire    = 1'b1;
        pc_src    = src;
        br_taken  = bt;
        br_offset = off;
        jr_target = jrt;
        irq       = irq_v;
        addr_q.push_back(exp_next);
        step();
        retire = 1'b0;
        irq    = 1'b0;
        pc_src = 3'b000;
        if (exp_vec) begin
            n_tests++;
            if (epc_we !== 1'b1 || epc !== exp_epc) begin
                n_fail++;
                $display("FAIL epc_pulse: we=%0b epc=%h, required 1/%h", epc_we, epc, exp_epc);
            end
            step();
            n_tests++;
            if (epc_we !== 1'b0 || epc !== exp_epc) begin
                n_fail++;
                $display("FAIL epc_hold: we=%0b epc=%h, required 0/%h", epc_we, epc, exp_epc);
            end
        end else begin
            n_tests++;
            if (epc_we !== 1'b0) begin
                n_fail++;
                $display("FAIL epc_we_idle: got %0b, required 0", epc_we);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_tests++;
        if (pc !== 32'h0 || imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 ||
            epc !== 32'h0 || epc_we !== 1'b0 || cycle_cnt !== 32'h0 || retire_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h req=%0b iv=%0b inst=%h epc=%h we=%0b cyc=%0d ret=%0d, required all zero",
                     pc, imem_req, inst_valid, inst, epc, epc_we, cycle_cnt, retire_cnt);
        end
        reset = 1'b0;
        step();
        n_tests++;
        if (imem_req !== 1'b1 || cycle_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL rst_to_fetch: req=%0b cyc=%0d, required 1/1", imem_req, cycle_cnt);
        end
        addr_q.delete();
        addr_q.push_back(32'h0);
    endtask

    task automatic test_seq();
        do_instr(3'b000, 0, 0, 0, 0, 32'h1111_0000, 32'h4, 0, 0);
        do_instr(3'b000, 0, 0, 0, 0, 32'h1111_0001, 32'h8, 0, 0);
        n_tests++;
        if (fetch_cyc - prev_fetch_cyc !== 32'd2) begin
            n_fail++;
            $display("FAIL seq_latency: got %0d cycles, required 2", fetch_cyc - prev_fetch_cyc);
        end
        do_instr(3'b000, 0, 0, 0, 0, 32'h1111_0002, 32'hC, 0, 0);
        n_tests++;
        if (retire_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL retire_cnt: got %0d, required 3", retire_cnt);
        end
        wait_fetch();
        n_tests++;
        if (cycle_cnt - fetch_cyc !== 32'd2 || imem_addr !== 32'hC) begin
            n_fail++;
            $display("FAIL seq_fourth_fetch: dcyc=%0d addr=%h, required 2/0000000c",
                     cycle_cnt - fetch_cyc, imem_addr);
        end
    endtask

    task automatic test_branch();
        do_instr(3'b000, 0, 0, 0, 0, 32'h0, 32'h10, 0, 0);
        do_instr(3'b001, 1, 32'hFFFF_FFFE, 0, 0, 32'h1000_FFFE, 32'h0C, 0, 0);
        do_instr(3'b000, 0, 0, 0, 0, 32'h0, 32'h10, 0, 0);
        do_instr(3'b001, 0, 32'hFFFF_FFFE, 0, 0, 32'h1000_FFFE, 32'h14, 0, 0);
    endtask

    task automatic test_jump_irq();
        do_instr(3'b000, 0, 0, 0, 0, 32'h0, 32'h18, 0, 0);
        do_instr(3'b000, 0, 0, 0, 0, 32'h0, 32'h1C, 0, 0);
        do_instr(3'b000, 0, 0, 0, 0, 32'h0, 32'h20, 0, 0);
        do_instr(3'b010, 0, 0, 0, 1, 32'h0800_0040, 32'h8000_0008, 1, 32'h100);
    endtask

    task automatic test_kernel_mask();
        do_instr(3'b000, 0, 0, 0, 1, 32'h0, 32'h8000_000C, 0, 0);
        do_instr(3'b000, 0, 0, 0, 1, 32'h0, 32'h8000_0010, 0, 0);
        do_instr(3'b011, 0, 0, 32'h40, 1, 32'h03E0_0008, 32'h8000_0008, 1, 32'h40);
    endtask

    task automatic test_misaligned_jr();
        do_instr(3'b011, 0, 0, 32'h42, 1, 32'h03E0_0008, 32'h8000_0004, 1, 32'h8000_0008);
    endtask

    task automatic test_vectors();
        do_instr(3'b100, 0, 0, 0, 0, 32'hFC00_0000, 32'h8000_0004, 1, 32'h8000_0008);
        do_instr(3'b101, 0, 0, 0, 0, 32'h0000_000C, 32'h8000_0008, 1, 32'h8000_0008);
        do_instr(3'b111, 0, 0, 0, 0, 32'hFC00_0000, 32'h8000_0004, 1, 32'h8000_000C);
        do_instr(3'b110, 0, 0, 0, 0, 32'hFC00_0000, 32'h8000_0004, 1, 32'h8000_0008);
        do_instr(3'b011, 0, 0, 32'h200, 0, 32'h03E0_0008, 32'h200, 0, 0);
        // Branches that wrap below the kernel bit in both directions.
        do_instr(3'b001, 1, 32'hFFFF_FF00, 0, 0, 32'h1000_FF00, 32'h7FFF_FE04, 0, 0);
        do_instr(3'b001, 1, 32'h0000_0100, 0, 0, 32'h1000_0100, 32'h208, 0, 0);
        do_instr(3'b100, 0, 0, 0, 1, 32'hFC00_0000, 32'h8000_0004, 1, 32'h20C);
    endtask

    task automatic test_ignore();
        logic [31:0] exp_addr;
        logic [31:0] ret_before;
        wait_fetch();
        exp_addr   = addr_q.pop_front();
        ret_before = retire_cnt;
        retire     = 1'b1;
        pc_src     = 3'b101;
        step();
        retire = 1'b0;
        pc_src = 3'b000;
        n_tests++;
        if (imem_req !== 1'b1 || retire_cnt !== ret_before || epc_we !== 1'b0 || pc !== exp_addr) begin
            n_fail++;
            $display("FAIL retire_in_fetch: req=%0b ret=%0d we=%0b pc=%h, required 1/%0d/0/%h",
                     imem_req, retire_cnt, epc_we, pc, ret_before, exp_addr);
        end
        imem_ack  = 1'b1;
        imem_data = 32'hAAAA_5555;
        step();
        imem_data = 32'h5555_AAAA;
        step();
        imem_ack = 1'b0;
        n_tests++;
        if (inst !== 32'hAAAA_5555 || inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_in_exec: inst=%h valid=%0b, required aaaa5555/1", inst, inst_valid);
        end
        retire = 1'b1;
        addr_q.push_back(exp_addr + 32'd4);
        step();
        retire = 1'b0;
        n_tests++;
        if (retire_cnt !== ret_before + 32'd1) begin
            n_fail++;
            $display("FAIL retire_after_ignore: got %0d, required %0d", retire_cnt, ret_before + 32'd1);
        end
    endtask

    task automatic test_reset_mid_fetch();
        wait_fetch();
        void'(addr_q.pop_front());
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        n_tests++;
        if (inst !== 32'h0 || pc !== 32'h0 || imem_req !== 1'b0 || inst_valid !== 1'b0 ||
            epc !== 32'h0 || cycle_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: inst=%h pc=%h req=%0b iv=%0b epc=%h cyc=%0d, required zeros",
                     inst, pc, imem_req, inst_valid, epc, cycle_cnt);
        end
        addr_q.delete();
        addr_q.push_back(32'h0);
        do_instr(3'b000, 0, 0, 0, 0, 32'h2222_0000, 32'h4, 0, 0);
        do_instr(3'b000, 0, 0, 0, 0, 32'h2222_0001, 32'h8, 0, 0);
        wait_fetch();
        n_tests++;
        if (imem_addr !== addr_q[0]) begin
            n_fail++;
            $display("FAIL restart_addr: got %h, required %h", imem_addr, addr_q[0]);
        end
    endtask

    initial begin
        reset     = 1'b1;
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        retire    = 1'b0;
        pc_src    = 3'b000;
        br_taken  = 1'b0;
        br_offset = 32'h0;
        jr_target = 32'h0;
        irq       = 1'b0;
        fetch_cyc      = 32'h0;
        prev_fetch_cyc = 32'h0;
        test_reset();
        test_seq();
        test_branch();
        test_jump_irq();
        test_kernel_mask();
        test_misaligned_jr();
        test_vectors();
        test_ignore();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
